usb_ep_dbuf: RTL and testbench
==============================

// Module: usb_ep_dbuf
// PURPOSE
//  Parametrised endpoint status/handshake engine: next-generation single-buffer endpoint.
//  Adds optional ping-pong buffering per direction, a configurable byte-count width and an isochronous mode.
//  Sits between the USB protocol engine (token/data/handshake side) and the CPU control register port.
//  Drives bank select, data toggle and handshake for the packet in flight.
// PARAMETERS
//  CNT_W    7  packet byte-count width, 1..16 (7 = 64 B bulk, 10 = 1023 B iso)
//  DUAL_BUF 1  1: two banks per direction (ping-pong); 0: single bank, bank output stuck 0
//  ISO      0  1: isochronous endpoint (no handshake, toggle fixed DATA0, no stall/setup)
// PORTS
//  clk            in   1      system clock, all state on rising edge
//  rst_n          in   1      async active-low reset
//  direction_in   in   1      current token is IN
//  setup          in   1      current token is SETUP
//  success        in   1      1-cycle pulse: transaction completed (data ACKed / received OK)
//  cnt            in   CNT_W  bytes moved/received in current transaction
//  toggle         out  1      expected/sent DATA0(0)/DATA1(1)
//  handshake      out  2      00 ACK, 01 NONE, 10 NAK, 11 STALL
//  bank           out  1      buffer bank used by current transaction
//  in_data_valid  out  1      IN: cnt != armed count of usb bank
//  ctrl_dir_in    in   1      CPU access selects IN(1)/OUT(0) side
//  ctrl_rd_data   out  32     status word (comb.)
//  ctrl_wr_data   in   32     command word
//  ctrl_wr_strobe in   1      1-cycle write strobe
// BEHAVIOUR
//  Interface: one clock; reset is asynchronous and active-low.
//  Reset: all flags 0, both bank pointers 0, counts 0, stalls 0, toggles 0.
//  Per direction: full[1:0], count[1:0], usb_ptr, cpu_ptr, toggle, stall, xrun; shared setup flag.
//  DUAL_BUF=0: pointers never advance.
//  bank = direction_in ? in.usb_ptr : out.usb_ptr.
//  Outputs toggle/handshake/bank/in_data_valid are combinational; state updates next clk edge.
//  Handshake IN: ACK if !stall & !setup & full[usb_ptr]; STALL if stall & !setup; else NAK.
//  Handshake OUT: ACK if setup token | (!stall & !setup & !full[usb_ptr]); STALL if stall & !setup; else NAK.
//  ISO overrides: OUT -> NONE always; IN -> ACK if full[usb_ptr] else NONE.
//   ISO toggle = 0; stall/setup bits read 0, writes ignored.
//  Toggle (non-ISO): OUT&setup -> 0; setup flag set -> 1; else direction toggle.
//  success IN: full[usb_ptr]<=0, usb_ptr flips, toggle flips.
//  success OUT: full[usb_ptr]<=1, count[usb_ptr]<=cnt, usb_ptr flips, toggle flips.
//   If the bank was already full (SETUP, or ISO OUT), set xrun.
//  success SETUP: additionally setup<=1; both stalls <=0; in.toggle<=1; out.toggle<=1.
//  ISO IN token with empty bank: xrun<=1 (underrun), on the handshake-NONE cycle (success low).
//  Write, side selected by ctrl_dir_in, acting on cpu_ptr bank:
//   wd[0]  commit; IN: count<=wd[CNT_W+15:16], full<=1, cpu_ptr flips
//   wd[1]  release; OUT: full<=0, cpu_ptr flips
//   wd[3]  clear setup (OUT side only)
//   wd[4]  stall value, written on every strobe
//   wd[6] set toggle; wd[7] clear toggle (wd[7] wins)
//   wd[8] clear xrun
//  Commit on a full bank or release on an empty bank: ignored, pointer unchanged.
//  Same-cycle success and write touching the same bank (only DUAL_BUF=0): CPU wins for full/count;
//   usb_ptr/toggle still update from success.
//  Read word: [0] full[cpu_ptr], [1] full[!cpu_ptr], [2] setup, [4] stall, [5] toggle, [8] xrun,
//   [9] cpu_ptr, [10] usb_ptr, [CNT_W+15:16] count[cpu_ptr]; other bits 0.
//  Reset asserted mid-transaction: all state cleared immediately; a pending success is lost.
// STRUCTURE
//  Package usb_pkg: handshake codes HS_ACK/HS_NONE/HS_NAK/HS_STALL; command/status bit-index constants.
//  Sub-module usb_ep_bankpair: full/count/ptr for one direction, instantiated twice (IN, OUT).
//  Top holds setup flag, toggles, stalls, xrun and the handshake/toggle muxes.
// TESTING
//  T1 DUAL_BUF=1 OUT: two OUT successes cnt=8,5 -> ACK,ACK, bank 0 then 1; 3rd OUT -> NAK;
//     release -> reads count 5, [0]=1; 3rd OUT -> ACK.
//  T2 IN ping-pong: commit cnt=64 then cnt=3 -> IN ACK bank0, success, IN ACK bank1 with in_data_valid=0 at cnt=3;
//     toggles 0,1,0.
//  T3 SETUP with stall set: SETUP success -> ACK; setup=1; stalls 0; IN token -> NAK, toggle 1;
//     clear setup -> IN NAK.
//  T4 Same-cycle collision, DUAL_BUF=0: OUT success and release in one cycle -> full=0; toggle flipped.
//  T5 ISO=1 CNT_W=10: IN with empty bank -> NONE, xrun=1; OUT cnt=1023 into full bank -> count 1023, xrun=1;
//     toggle always 0.
//  T6 rst_n low mid-test, async to clk -> all status 0, handshake (OUT) ACK, bank 0 before next edge.

Source files
------------

// File: rtl/usb_pkg.sv
// Shared definitions for the USB endpoint status/handshake engine.
//   hs_e          : handshake codes driven towards the protocol engine
//   CMD_*         : bit positions in the CPU command word
//   ST_*          : bit positions in the CPU status word
//   CNT_LSB       : LSB of the byte-count field in both words
package usb_pkg;

    typedef enum logic [1:0] {
        HS_ACK   = 2'b00,
        HS_NONE  = 2'b01,
        HS_NAK   = 2'b10,
        HS_STALL = 2'b11
    } hs_e;

    localparam int unsigned CMD_COMMIT    = 0;
    localparam int unsigned CMD_RELEASE   = 1;
    localparam int unsigned CMD_CLR_SETUP = 3;
    localparam int unsigned CMD_STALL     = 4;
    localparam int unsigned CMD_SET_TOG   = 6;
    localparam int unsigned CMD_CLR_TOG   = 7;
    localparam int unsigned CMD_CLR_XRUN  = 8;

    localparam int unsigned ST_FULL_CUR = 0;
    localparam int unsigned ST_FULL_OTH = 1;
    localparam int unsigned ST_SETUP    = 2;
    localparam int unsigned ST_STALL    = 4;
    localparam int unsigned ST_TOGGLE   = 5;
    localparam int unsigned ST_XRUN     = 8;
    localparam int unsigned ST_CPU_PTR  = 9;
    localparam int unsigned ST_USB_PTR  = 10;

    localparam int unsigned CNT_LSB = 16;

endpackage

// File: rtl/usb_ep_bankpair.sv
// Buffer bookkeeping for one endpoint direction: two banks (or one when
// DUAL_BUF=0), each with a full flag and a byte count, plus the USB-side and
// CPU-side bank pointers.
//   usb_evt     : transaction completed on this direction
//   usb_fill    : 1 = USB fills the bank (OUT), 0 = USB drains it (IN)
//   usb_cnt     : byte count stored on a fill
//   cpu_commit  : CPU hands a filled bank to USB (ignored if bank full)
//   cpu_release : CPU gives an emptied bank back (ignored if bank empty)
//   cpu_cnt     : byte count stored on a commit
//   full/count  : per-bank state, usb_ptr/cpu_ptr : bank pointers
module usb_ep_bankpair #(
    parameter int unsigned CNT_W    = 7,
    parameter int unsigned DUAL_BUF = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  usb_evt,
    input  logic                  usb_fill,
    input  logic [CNT_W-1:0]      usb_cnt,
    input  logic                  cpu_commit,
    input  logic                  cpu_release,
    input  logic [CNT_W-1:0]      cpu_cnt,
    output logic [1:0]            full,
    output logic [1:0][CNT_W-1:0] count,
    output logic                  usb_ptr,
    output logic                  cpu_ptr
);

    localparam bit PP = (DUAL_BUF != 0);

    logic commit_ok;
    logic release_ok;

    assign commit_ok  = cpu_commit  & ~full[cpu_ptr];
    assign release_ok = cpu_release &  full[cpu_ptr];

    // CPU updates come last so they win when both sides hit the same bank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full    <= '0;
            count   <= '0;
            usb_ptr <= 1'b0;
            cpu_ptr <= 1'b0;
        end else begin
            if (usb_evt) begin
                full[usb_ptr] <= usb_fill;
                if (usb_fill) begin
                    count[usb_ptr] <= usb_cnt;
                end
                if (PP) begin
                    usb_ptr <= ~usb_ptr;
                end
            end
            if (commit_ok) begin
                full[cpu_ptr]  <= 1'b1;
                count[cpu_ptr] <= cpu_cnt;
                if (PP) begin
                    cpu_ptr <= ~cpu_ptr;
                end
            end
            if (release_ok) begin
                full[cpu_ptr] <= 1'b0;
                if (PP) begin
                    cpu_ptr <= ~cpu_ptr;
                end
            end
        end
    end

endmodule

// File: rtl/usb_ep_dbuf.sv
// Endpoint status/handshake engine with optional ping-pong buffering and
// isochronous mode, between the USB protocol engine and the CPU register port.
//   direction_in/setup/success/cnt : token side from the protocol engine
//   toggle/handshake/bank/in_data_valid : combinational response for the
//                                         transaction in flight
//   ctrl_dir_in/ctrl_wr_data/ctrl_wr_strobe : CPU command port
//   ctrl_rd_data : combinational status word of the side ctrl_dir_in selects
module usb_ep_dbuf
    import usb_pkg::*;
#(
    parameter int unsigned CNT_W    = 7,
    parameter int unsigned DUAL_BUF = 1,
    parameter int unsigned ISO      = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             direction_in,
    input  logic             setup,
    input  logic             success,
    input  logic [CNT_W-1:0] cnt,
    output logic             toggle,
    output logic [1:0]       handshake,
    output logic             bank,
    output logic             in_data_valid,
    input  logic             ctrl_dir_in,
    output logic [31:0]      ctrl_rd_data,
    input  logic [31:0]      ctrl_wr_data,
    input  logic             ctrl_wr_strobe
);

    localparam bit ISO_B = (ISO != 0);

    logic                  setup_tok;
    logic                  succ_in;
    logic                  succ_out;
    logic                  setup_done;
    logic                  wr_in;
    logic                  wr_out;
    logic [CNT_W-1:0]      wr_cnt;
    logic                  unused_wd;

    logic [1:0]            in_full;
    logic [1:0][CNT_W-1:0] in_count;
    logic                  in_usb_ptr;
    logic                  in_cpu_ptr;
    logic [1:0]            out_full;
    logic [1:0][CNT_W-1:0] out_count;
    logic                  out_usb_ptr;
    logic                  out_cpu_ptr;
    logic                  in_full_usb;
    logic                  out_full_usb;

    logic                  setup_q;
    logic                  tog_in;
    logic                  tog_out;
    logic                  stall_in;
    logic                  stall_out;
    logic                  xrun_in;
    logic                  xrun_out;
    logic                  xrun_in_set;
    logic                  xrun_out_set;

    hs_e                   hs_c;

    // Isochronous endpoints have no SETUP handling at all.
    assign setup_tok  = setup & ~direction_in & ~ISO_B;
    assign succ_in    = success &  direction_in;
    assign succ_out   = success & ~direction_in;
    assign setup_done = succ_out & setup_tok;
    assign wr_in      = ctrl_wr_strobe &  ctrl_dir_in;
    assign wr_out     = ctrl_wr_strobe & ~ctrl_dir_in;
    assign wr_cnt     = ctrl_wr_data[CNT_LSB +: CNT_W];
    assign unused_wd  = ^ctrl_wr_data;

    usb_ep_bankpair #(.CNT_W(CNT_W), .DUAL_BUF(DUAL_BUF)) u_in (
        .clk         (clk),
        .rst_n       (rst_n),
        .usb_evt     (succ_in),
        .usb_fill    (1'b0),
        .usb_cnt     (cnt),
        .cpu_commit  (wr_in & ctrl_wr_data[CMD_COMMIT]),
        .cpu_release (1'b0),
        .cpu_cnt     (wr_cnt),
        .full        (in_full),
        .count       (in_count),
        .usb_ptr     (in_usb_ptr),
        .cpu_ptr     (in_cpu_ptr)
    );

    usb_ep_bankpair #(.CNT_W(CNT_W), .DUAL_BUF(DUAL_BUF)) u_out (
        .clk         (clk),
        .rst_n       (rst_n),
        .usb_evt     (succ_out),
        .usb_fill    (1'b1),
        .usb_cnt     (cnt),
        .cpu_commit  (1'b0),
        .cpu_release (wr_out & ctrl_wr_data[CMD_RELEASE]),
        .cpu_cnt     (wr_cnt),
        .full        (out_full),
        .count       (out_count),
        .usb_ptr     (out_usb_ptr),
        .cpu_ptr     (out_cpu_ptr)
    );

    assign in_full_usb  = in_full[in_usb_ptr];
    assign out_full_usb = out_full[out_usb_ptr];

    // Overrun: SETUP or iso OUT landing on a full bank. Underrun: iso IN with nothing armed.
    assign xrun_out_set = succ_out & out_full_usb & (setup_tok | ISO_B);
    assign xrun_in_set  = ISO_B & direction_in & ~in_full_usb & ~success;

    // Toggle, stall and setup flag; CPU writes land last and win on a clash.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            setup_q   <= 1'b0;
            tog_in    <= 1'b0;
            tog_out   <= 1'b0;
            stall_in  <= 1'b0;
            stall_out <= 1'b0;
        end else if (!ISO_B) begin
            if (succ_in) begin
                tog_in <= ~tog_in;
            end
            if (succ_out) begin
                tog_out <= ~tog_out;
            end
            if (setup_done) begin
                setup_q   <= 1'b1;
                stall_in  <= 1'b0;
                stall_out <= 1'b0;
                tog_in    <= 1'b1;
                tog_out   <= 1'b1;
            end
            if (wr_in) begin
                stall_in <= ctrl_wr_data[CMD_STALL];
                if (ctrl_wr_data[CMD_SET_TOG]) tog_in <= 1'b1;
                if (ctrl_wr_data[CMD_CLR_TOG]) tog_in <= 1'b0;
            end
            if (wr_out) begin
                stall_out <= ctrl_wr_data[CMD_STALL];
                if (ctrl_wr_data[CMD_SET_TOG])   tog_out <= 1'b1;
                if (ctrl_wr_data[CMD_CLR_TOG])   tog_out <= 1'b0;
                if (ctrl_wr_data[CMD_CLR_SETUP]) setup_q <= 1'b0;
            end
        end
    end

    // Over/underrun flags, sticky until the CPU clears them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xrun_in  <= 1'b0;
            xrun_out <= 1'b0;
        end else begin
            if (xrun_in_set)  xrun_in  <= 1'b1;
            if (xrun_out_set) xrun_out <= 1'b1;
            if (wr_in  && ctrl_wr_data[CMD_CLR_XRUN]) xrun_in  <= 1'b0;
            if (wr_out && ctrl_wr_data[CMD_CLR_XRUN]) xrun_out <= 1'b0;
        end
    end

    // Handshake for the token in flight.
    always_comb begin
        hs_c = HS_NAK;
        if (ISO_B) begin
            hs_c = (direction_in && in_full_usb) ? HS_ACK : HS_NONE;
        end else if (direction_in) begin
            if (stall_in && !setup_q) begin
                hs_c = HS_STALL;
            end else if (!stall_in && !setup_q && in_full_usb) begin
                hs_c = HS_ACK;
            end
        end else begin
            if (setup_tok) begin
                hs_c = HS_ACK;
            end else if (stall_out && !setup_q) begin
                hs_c = HS_STALL;
            end else if (!stall_out && !setup_q && !out_full_usb) begin
                hs_c = HS_ACK;
            end
        end
    end

    // A SETUP packet is always DATA0; the status stage after it is DATA1.
    always_comb begin
        toggle = 1'b0;
        if (!ISO_B) begin
            if (setup_tok) begin
                toggle = 1'b0;
            end else if (setup_q) begin
                toggle = 1'b1;
            end else begin
                toggle = direction_in ? tog_in : tog_out;
            end
        end
    end

    assign handshake     = hs_c;
    assign bank          = direction_in ? in_usb_ptr : out_usb_ptr;
    assign in_data_valid = direction_in & (cnt != in_count[in_usb_ptr]);

    // Status word of the side the CPU is addressing.
    always_comb begin
        logic [1:0]            s_full;
        logic [1:0][CNT_W-1:0] s_count;
        logic                  s_cpu;
        logic                  s_usb;
        s_full  = ctrl_dir_in ? in_full     : out_full;
        s_count = ctrl_dir_in ? in_count    : out_count;
        s_cpu   = ctrl_dir_in ? in_cpu_ptr  : out_cpu_ptr;
        s_usb   = ctrl_dir_in ? in_usb_ptr  : out_usb_ptr;
        ctrl_rd_data                      = '0;
        ctrl_rd_data[ST_FULL_CUR]         = s_full[s_cpu];
        ctrl_rd_data[ST_FULL_OTH]         = s_full[~s_cpu];
        ctrl_rd_data[ST_SETUP]            = setup_q;
        ctrl_rd_data[ST_STALL]            = ctrl_dir_in ? stall_in : stall_out;
        ctrl_rd_data[ST_TOGGLE]           = ctrl_dir_in ? tog_in : tog_out;
        ctrl_rd_data[ST_XRUN]             = ctrl_dir_in ? xrun_in : xrun_out;
        ctrl_rd_data[ST_CPU_PTR]          = s_cpu;
        ctrl_rd_data[ST_USB_PTR]          = s_usb;
        ctrl_rd_data[CNT_LSB +: CNT_W]    = s_count[s_cpu];
    end

endmodule

// File: tb/tb_usb_ep_dbuf.sv
// Directed bench for usb_ep_dbuf: a vector table on the default ping-pong
// endpoint, then hand sequences on a single-buffer and an isochronous instance
// and an asynchronous reset in mid-transaction.
module tb_usb_ep_dbuf;

    localparam logic [1:0] H_ACK   = 2'b00;
    localparam logic [1:0] H_NONE  = 2'b01;
    localparam logic [1:0] H_NAK   = 2'b10;
    localparam logic [1:0] H_STALL = 2'b11;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // main instance: CNT_W=7, DUAL_BUF=1, ISO=0
    logic m_dir = 0, m_stp = 0, m_suc = 0, m_cdir = 0, m_wstb = 0;
    logic [6:0] m_cnt = '0;
    logic [31:0] m_wd = '0;
    logic m_tog, m_bnk, m_idv;
    logic [1:0] m_hs;
    logic [31:0] m_rd;

    usb_ep_dbuf #(.CNT_W(7), .DUAL_BUF(1), .ISO(0)) u_dut (
        .clk(clk), .rst_n(rst_n), .direction_in(m_dir), .setup(m_stp), .success(m_suc),
        .cnt(m_cnt), .toggle(m_tog), .handshake(m_hs), .bank(m_bnk), .in_data_valid(m_idv),
        .ctrl_dir_in(m_cdir), .ctrl_rd_data(m_rd), .ctrl_wr_data(m_wd), .ctrl_wr_strobe(m_wstb)
    );

    // single-buffer instance
    logic s_dir = 0, s_stp = 0, s_suc = 0, s_cdir = 0, s_wstb = 0;
    logic [6:0] s_cnt = '0;
    logic [31:0] s_wd = '0;
    logic s_tog, s_bnk, s_idv;
    logic [1:0] s_hs;
    logic [31:0] s_rd;

    usb_ep_dbuf #(.CNT_W(7), .DUAL_BUF(0), .ISO(0)) u_sb (
        .clk(clk), .rst_n(rst_n), .direction_in(s_dir), .setup(s_stp), .success(s_suc),
        .cnt(s_cnt), .toggle(s_tog), .handshake(s_hs), .bank(s_bnk), .in_data_valid(s_idv),
        .ctrl_dir_in(s_cdir), .ctrl_rd_data(s_rd), .ctrl_wr_data(s_wd), .ctrl_wr_strobe(s_wstb)
    );

    // isochronous instance
    logic i_dir = 0, i_stp = 0, i_suc = 0, i_cdir = 0, i_wstb = 0;
    logic [9:0] i_cnt = '0;
    logic [31:0] i_wd = '0;
    logic i_tog, i_bnk, i_idv;
    logic [1:0] i_hs;
    logic [31:0] i_rd;

    usb_ep_dbuf #(.CNT_W(10), .DUAL_BUF(1), .ISO(1)) u_iso (
        .clk(clk), .rst_n(rst_n), .direction_in(i_dir), .setup(i_stp), .success(i_suc),
        .cnt(i_cnt), .toggle(i_tog), .handshake(i_hs), .bank(i_bnk), .in_data_valid(i_idv),
        .ctrl_dir_in(i_cdir), .ctrl_rd_data(i_rd), .ctrl_wr_data(i_wd), .ctrl_wr_strobe(i_wstb)
    );

    typedef struct {
        logic        dir;
        logic        stp;
        logic        suc;
        logic [6:0]  cnt;
        logic        cdir;
        logic        wstb;
        logic [31:0] wd;
        logic [1:0]  hs;
        logic        tog;
        logic        bnk;
        logic        idv;
        logic [31:0] rd;
    } vec_t;

    localparam int NV = 25;
    vec_t tv [NV];

    function automatic vec_t mk(input logic dir, input logic stp, input logic suc,
                                input logic [6:0] cnt, input logic cdir, input logic wstb,
                                input logic [31:0] wd, input logic [1:0] hs, input logic tog,
                                input logic bnk, input logic idv, input logic [31:0] rd);
        vec_t v;
        v.dir = dir; v.stp = stp; v.suc = suc; v.cnt = cnt; v.cdir = cdir; v.wstb = wstb;
        v.wd = wd; v.hs = hs; v.tog = tog; v.bnk = bnk; v.idv = idv; v.rd = rd;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //            dir stp suc cnt cdir wstb wd            hs      tog bnk idv rd
        // ping-pong OUT
        tv[0]  = mk(0, 0, 0, 7'd0,  0, 0, 32'h0,         H_ACK,   0, 0, 0, 32'h0000_0000);
        tv[1]  = mk(0, 0, 1, 7'd8,  0, 0, 32'h0,         H_ACK,   0, 0, 0, 32'h0000_0000);
        tv[2]  = mk(0, 0, 1, 7'd5,  0, 0, 32'h0,         H_ACK,   1, 1, 0, 32'h0008_0421);
        tv[3]  = mk(0, 0, 0, 7'd0,  0, 0, 32'h0,         H_NAK,   0, 0, 0, 32'h0008_0003);
        tv[4]  = mk(0, 0, 0, 7'd0,  0, 1, 32'h2,         H_NAK,   0, 0, 0, 32'h0008_0003);
        tv[5]  = mk(0, 0, 0, 7'd0,  0, 0, 32'h0,         H_ACK,   0, 0, 0, 32'h0005_0201);
        // ping-pong IN
        tv[6]  = mk(0, 0, 0, 7'd0,  1, 1, 32'h0040_0001, H_ACK,   0, 0, 0, 32'h0000_0000);
        tv[7]  = mk(0, 0, 0, 7'd0,  1, 1, 32'h0003_0001, H_ACK,   0, 0, 0, 32'h0000_0202);
        tv[8]  = mk(1, 0, 0, 7'd10, 1, 0, 32'h0,         H_ACK,   0, 0, 1, 32'h0040_0003);
        tv[9]  = mk(1, 0, 1, 7'd64, 1, 0, 32'h0,         H_ACK,   0, 0, 0, 32'h0040_0003);
        tv[10] = mk(1, 0, 0, 7'd3,  1, 0, 32'h0,         H_ACK,   1, 1, 0, 32'h0040_0422);
        tv[11] = mk(1, 0, 1, 7'd3,  1, 0, 32'h0,         H_ACK,   1, 1, 0, 32'h0040_0422);
        tv[12] = mk(1, 0, 0, 7'd0,  1, 0, 32'h0,         H_NAK,   0, 0, 1, 32'h0040_0000);
        // stall both sides, then SETUP
        tv[13] = mk(0, 0, 0, 7'd0,  0, 1, 32'h10,        H_ACK,   0, 0, 0, 32'h0005_0201);
        tv[14] = mk(0, 0, 0, 7'd0,  1, 1, 32'h10,        H_STALL, 0, 0, 0, 32'h0040_0000);
        tv[15] = mk(0, 1, 1, 7'd8,  0, 0, 32'h0,         H_ACK,   0, 0, 0, 32'h0005_0211);
        tv[16] = mk(1, 0, 0, 7'd0,  0, 0, 32'h0,         H_NAK,   1, 0, 1, 32'h0005_0627);
        tv[17] = mk(1, 0, 0, 7'd0,  0, 1, 32'h8,         H_NAK,   1, 0, 1, 32'h0005_0627);
        tv[18] = mk(1, 0, 0, 7'd0,  0, 0, 32'h0,         H_NAK,   1, 0, 1, 32'h0005_0623);
        // toggle set+clear (clear wins), commit into full bank ignored
        tv[19] = mk(1, 0, 0, 7'd0,  1, 1, 32'hC0,        H_NAK,   1, 0, 1, 32'h0040_0020);
        tv[20] = mk(1, 0, 0, 7'd0,  1, 0, 32'h0,         H_NAK,   0, 0, 1, 32'h0040_0000);
        tv[21] = mk(1, 0, 0, 7'd0,  1, 1, 32'h0009_0001, H_NAK,   0, 0, 1, 32'h0040_0000);
        tv[22] = mk(1, 0, 0, 7'd0,  1, 1, 32'h0007_0001, H_ACK,   0, 0, 1, 32'h0003_0202);
        tv[23] = mk(1, 0, 0, 7'd0,  1, 1, 32'h0011_0001, H_ACK,   0, 0, 1, 32'h0009_0003);
        tv[24] = mk(1, 0, 0, 7'd0,  1, 0, 32'h0,         H_ACK,   0, 0, 1, 32'h0009_0003);

        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            m_dir = tv[i].dir; m_stp = tv[i].stp; m_suc = tv[i].suc; m_cnt = tv[i].cnt;
            m_cdir = tv[i].cdir; m_wstb = tv[i].wstb; m_wd = tv[i].wd;
            #1;
            chk($sformatf("row%0d handshake", i), 32'(m_hs), 32'(tv[i].hs));
            chk($sformatf("row%0d toggle", i), 32'(m_tog), 32'(tv[i].tog));
            chk($sformatf("row%0d bank", i), 32'(m_bnk), 32'(tv[i].bnk));
            chk($sformatf("row%0d in_data_valid", i), 32'(m_idv), 32'(tv[i].idv));
            chk($sformatf("row%0d rd_data", i), m_rd, tv[i].rd);
        end
        @(negedge clk);
        m_stp = 0; m_suc = 0; m_wstb = 0; m_wd = '0; m_cnt = '0;

        // single buffer: success and release on the same bank in one cycle
        @(negedge clk);
        s_dir = 0; s_suc = 1; s_cnt = 7'd4;
        #1 chk("sb first out hs", 32'(s_hs), 32'(H_ACK));
        @(negedge clk);
        s_suc = 0;
        #1 chk("sb after out rd", s_rd, 32'h0004_0021);
        chk("sb full hs", 32'(s_hs), 32'(H_NAK));
        chk("sb bank stuck", 32'(s_bnk), 32'd0);
        @(negedge clk);
        s_suc = 1; s_cnt = 7'd6; s_cdir = 0; s_wstb = 1; s_wd = 32'h2;
        #1 chk("sb pre collision tog", 32'(s_tog), 32'd1);
        @(negedge clk);
        s_suc = 0; s_wstb = 0; s_wd = '0;
        #1 chk("sb collision rd", s_rd & 32'h0000_FFFF, 32'h0000_0000);
        chk("sb collision hs", 32'(s_hs), 32'(H_ACK));
        s_wstb = 1; s_wd = 32'h2;
        @(negedge clk);
        s_wstb = 0; s_wd = '0;
        #1 chk("sb release empty rd", s_rd & 32'h0000_FFFF, 32'h0000_0000);
        s_cdir = 1; s_wstb = 1; s_wd = 32'h0002_0001;
        @(negedge clk);
        s_wd = 32'h0009_0001;
        @(negedge clk);
        s_wstb = 0; s_wd = '0;
        #1 chk("sb commit full ignored rd", s_rd, 32'h0002_0001);

        // isochronous instance
        @(negedge clk);
        i_dir = 1; i_cdir = 1;
        #1 chk("iso in empty hs", 32'(i_hs), 32'(H_NONE));
        chk("iso in tog", 32'(i_tog), 32'd0);
        @(negedge clk);
        i_dir = 0;
        #1 chk("iso underrun rd", i_rd, 32'h0000_0100);
        chk("iso out hs", 32'(i_hs), 32'(H_NONE));
        i_wstb = 1; i_wd = 32'h0005_0101;
        @(negedge clk);
        i_wstb = 0; i_wd = '0; i_dir = 1;
        #1 chk("iso in armed hs", 32'(i_hs), 32'(H_ACK));
        chk("iso in armed tog", 32'(i_tog), 32'd0);
        chk("iso commit rd", i_rd, 32'h0000_0202);
        @(negedge clk);
        i_dir = 0; i_suc = 1; i_cnt = 10'd100;
        #1 chk("iso out succ hs", 32'(i_hs), 32'(H_NONE));
        @(negedge clk);
        i_cnt = 10'd200;
        @(negedge clk);
        i_cnt = 10'd1023;
        @(negedge clk);
        i_suc = 0; i_cnt = '0; i_cdir = 0; i_wstb = 1; i_wd = 32'h50;
        #1 chk("iso out tog", 32'(i_tog), 32'd0);
        @(negedge clk);
        i_wstb = 0; i_wd = '0;
        #1 chk("iso overrun rd", i_rd, 32'h03FF_0503);
        chk("iso bank", 32'(i_bnk), 32'd1);

        // asynchronous reset between edges with a success pending
        @(negedge clk);
        m_dir = 0; m_suc = 1; m_cnt = 7'd5; m_cdir = 0;
        #1 chk("pre reset hs", 32'(m_hs), 32'(H_NAK));
        #1 rst_n = 1'b0;
        #1 chk("reset hs", 32'(m_hs), 32'(H_ACK));
        chk("reset bank", 32'(m_bnk), 32'd0);
        chk("reset tog", 32'(m_tog), 32'd0);
        chk("reset out rd", m_rd, 32'h0);
        m_cdir = 1;
        #1 chk("reset in rd", m_rd, 32'h0);
        @(negedge clk);
        m_suc = 0; m_cnt = '0; rst_n = 1'b1;
        #1 chk("post reset in rd", m_rd, 32'h0);
        m_cdir = 0;
        #1 chk("post reset out rd", m_rd, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
